// File: rtl/or_reduce_frame.sv
// Frame-level OR reduction over a valid/ready word stream: reports any-bit-set, word count and
// (when OR_REDUCE_BITMAP_EN is defined) the per-bit OR of all words in each frame.
module or_reduce_frame #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_any,
  output logic [CNT_W-1:0] out_count,
  output logic [WIDTH-1:0] out_bitmap
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b1}}) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + CNT_W'(1'b1);
    end
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             in_ready_r;
  logic             in_ready_nxt_s;
  logic             out_valid_r;
  logic             out_valid_nxt_s;
  logic             out_any_r;
  logic             out_any_nxt_s;
  logic [CNT_W-1:0] out_count_r;
  logic [CNT_W-1:0] out_count_nxt_s;
  logic             acc_any_r;
  logic             acc_any_nxt_s;
  logic [CNT_W-1:0] acc_cnt_r;
  logic [CNT_W-1:0] acc_cnt_nxt_s;
  logic             beat_s;
  logic             word_any_s;

  assign beat_s     = in_valid & in_ready_r;
  assign word_any_s = |in_data;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_any   = out_any_r;
  assign out_count = out_count_r;

  // Next-state and next-register values for the control path.
  always_comb begin
    state_nxt_s     = state_r;
    in_ready_nxt_s  = in_ready_r;
    out_valid_nxt_s = out_valid_r;
    out_any_nxt_s   = out_any_r;
    out_count_nxt_s = out_count_r;
    acc_any_nxt_s   = acc_any_r;
    acc_cnt_nxt_s   = acc_cnt_r;
    case (state_r)
      ST_ACC: begin
        if (beat_s) begin
          acc_any_nxt_s = acc_any_r | word_any_s;
          acc_cnt_nxt_s = sat_inc(acc_cnt_r);
          if (in_last) begin
            // Result includes the closing beat itself.
            state_nxt_s     = ST_OUT;
            in_ready_nxt_s  = 1'b0;
            out_valid_nxt_s = 1'b1;
            out_any_nxt_s   = acc_any_r | word_any_s;
            out_count_nxt_s = sat_inc(acc_cnt_r);
          end else begin
            state_nxt_s = ST_ACC;
          end
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_nxt_s     = ST_ACC;
          in_ready_nxt_s  = 1'b1;
          out_valid_nxt_s = 1'b0;
          acc_any_nxt_s   = 1'b0;
          acc_cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s     = ST_ACC;
        in_ready_nxt_s  = 1'b1;
        out_valid_nxt_s = 1'b0;
        acc_any_nxt_s   = 1'b0;
        acc_cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Control-path registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_ACC;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_any_r   <= 1'b0;
      out_count_r <= {CNT_W{1'b0}};
      acc_any_r   <= 1'b0;
      acc_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_any_r   <= out_any_nxt_s;
      out_count_r <= out_count_nxt_s;
      acc_any_r   <= acc_any_nxt_s;
      acc_cnt_r   <= acc_cnt_nxt_s;
    end
  end

`ifdef OR_REDUCE_BITMAP_EN
  logic [WIDTH-1:0] acc_map_r;
  logic [WIDTH-1:0] acc_map_nxt_s;
  logic [WIDTH-1:0] out_bitmap_r;
  logic [WIDTH-1:0] out_bitmap_nxt_s;

  assign out_bitmap = out_bitmap_r;

  // Bitmap accumulator follows the same load/clear timing as out_any.
  always_comb begin
    acc_map_nxt_s    = acc_map_r;
    out_bitmap_nxt_s = out_bitmap_r;
    case (state_r)
      ST_ACC: begin
        if (beat_s) begin
          acc_map_nxt_s = acc_map_r | in_data;
          if (in_last) begin
            out_bitmap_nxt_s = acc_map_r | in_data;
          end else begin
            out_bitmap_nxt_s = out_bitmap_r;
          end
        end else begin
          acc_map_nxt_s = acc_map_r;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          acc_map_nxt_s = {WIDTH{1'b0}};
        end else begin
          acc_map_nxt_s = acc_map_r;
        end
      end
      default: begin
        acc_map_nxt_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // Bitmap registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_map_r    <= {WIDTH{1'b0}};
      out_bitmap_r <= {WIDTH{1'b0}};
    end else begin
      acc_map_r    <= acc_map_nxt_s;
      out_bitmap_r <= out_bitmap_nxt_s;
    end
  end
`else
  assign out_bitmap = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_or_reduce_frame.sv
// Scoreboard bench for or_reduce_frame: an 8/8 instance for most frames and an 8/2 instance for
// counter saturation; expected results are queued when the closing beat is accepted.
module tb_or_reduce_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid;
  logic       sel;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       a_ivalid, a_ready, a_ovalid, a_any;
  logic [7:0] a_cnt, a_map;
  logic       b_ivalid, b_ready, b_ovalid, b_any;
  logic [1:0] b_cnt;
  logic [7:0] b_map;

  assign a_ivalid = in_valid & ~sel;
  assign b_ivalid = in_valid & sel;

  or_reduce_frame #(.WIDTH(8), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_ivalid), .in_ready(a_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(a_ovalid), .out_ready(out_ready), .out_any(a_any),
    .out_count(a_cnt), .out_bitmap(a_map)
  );

  or_reduce_frame #(.WIDTH(8), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_ivalid), .in_ready(b_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(b_ovalid), .out_ready(out_ready), .out_any(b_any),
    .out_count(b_cnt), .out_bitmap(b_map)
  );

  typedef struct packed {
    logic       any;
    logic [7:0] cnt;
    logic [7:0] map;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef OR_REDUCE_BITMAP_EN
  logic [7:0] bm_mask = 8'hFF;
`else
  logic [7:0] bm_mask = 8'h00;
`endif

  logic       m_any;
  int         m_cnt;
  logic [7:0] m_map;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_any = 1'b0;
    m_cnt = 0;
    m_map = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; returns #1 after the accepting edge and updates the model.
  task automatic send(input logic [7:0] d, input logic l);
    bit   ok;
    int   maxc;
    exp_t e;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (sel ? b_ready : a_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      check("accept_timeout", 0, 1);
    end else begin
      maxc  = sel ? 3 : 255;
      m_any = m_any | (|d);
      m_map = m_map | d;
      if (m_cnt < maxc) m_cnt++;
      if (l) begin
        e.any = m_any;
        e.cnt = m_cnt[7:0];
        e.map = m_map & bm_mask;
        if (sel) qb.push_back(e);
        else qa.push_back(e);
        model_clear();
      end
    end
  endtask

  task automatic wait_valid_a();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (a_ovalid) ok = 1'b1;
    end
    if (!ok) check("valid_timeout", 0, 1);
    tick();
  endtask

  // Scoreboard monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!reset && a_ovalid && out_ready) begin
      if (qa.size() == 0) begin
        check("a_extra_result", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_any", a_any, e.any);
        check("a_count", a_cnt, e.cnt);
        check("a_bitmap", a_map, e.map);
      end
    end
    if (!reset && b_ovalid && out_ready) begin
      if (qb.size() == 0) begin
        check("b_extra_result", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_any", b_any, e.any);
        check("b_count", b_cnt, e.cnt);
        check("b_bitmap", b_map, e.map);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    sel       = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    model_clear();
    tick();
    @(negedge clk);
    check("rst_out_valid", a_ovalid, 0);
    check("rst_in_ready", a_ready, 1);
    check("rst_any", a_any, 0);
    check("rst_count", a_cnt, 0);
    check("rst_bitmap", a_map, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single-beat frame with latency and return-to-accept checks.
    send(8'h40, 1'b1);
    @(negedge clk);
    check("t1_latency", a_ovalid, 1);
    tick();
    @(negedge clk);
    check("t1_back_ready", a_ready, 1);
    check("t1_back_valid", a_ovalid, 0);
    tick();

    // Frame with an idle gap mid-frame.
    send(8'h00, 1'b0);
    tick();
    tick();
    send(8'h00, 1'b0);
    send(8'h01, 1'b1);
    repeat (3) tick();

    // All-zero single word.
    send(8'h00, 1'b1);
    repeat (3) tick();

    // Backpressure: result held, new word refused.
    out_ready = 1'b0;
    send(8'h05, 1'b1);
    wait_valid_a();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", a_ready, 0);
      check("bp_out_valid", a_ovalid, 1);
      check("bp_any", a_any, 1);
      check("bp_count", a_cnt, 1);
      check("bp_bitmap", a_map, 8'h05 & bm_mask);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    repeat (3) tick();

    // Counter saturation on the CNT_W=2 instance.
    sel = 1'b1;
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h80, 1'b1);
    repeat (3) tick();
    sel = 1'b0;

    // Reset mid-frame discards the partial frame immediately.
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_valid", a_ovalid, 0);
    check("rst_mid_ready", a_ready, 1);
    check("rst_mid_count", a_cnt, 0);
    model_clear();
    tick();
    reset = 1'b0;
    tick();
    send(8'h00, 1'b1);
    repeat (3) tick();

    // Reset while a result is pending drops it.
    out_ready = 1'b0;
    send(8'h33, 1'b1);
    wait_valid_a();
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid_drop", a_ovalid, 0);
    check("rst_out_any_drop", a_any, 0);
    qa.delete();
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    send(8'h10, 1'b1);

    for (int t = 0; t < 50 && (qa.size() + qb.size()) != 0; t++) tick();
    check("drain", qa.size() + qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
